// File: rtl/fuzz_seq_pkg.sv
// Shared types and arithmetic for the fuzz stimulus sequencer.
// LCG step, response folding and sequencer state encoding.
package fuzz_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN0,
    RHOLD,
    GEN,
    APPLY,
    FIN
  } seq_state_e;

  localparam logic [31:0] LCG_MUL   = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC   = 32'h3039;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam int          FOLD_MAX  = 512;

  function automatic logic [31:0] lcg_next(
    input logic [31:0] s
  );
    return s * LCG_MUL + LCG_INC;
  endfunction

  // Callers zero-extend narrower responses into FOLD_MAX bits.
  function automatic logic [31:0] fold32(
    input logic [FOLD_MAX-1:0] x
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < FOLD_MAX / 32; i++)
      r ^= x[i*32 +: 32];
    return r;
  endfunction

endpackage

// File: rtl/fuzz_misr32.sv
// 32-bit MISR compacting folded DUT responses.
// Clear has priority over enable.
module fuzz_misr32
  import fuzz_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr)
      sig_d = '0;
    else if (en)
      sig_d = {sig_q[30:0], 1'b0}
            ^ (sig_q[31] ? MISR_POLY : 32'h0)
            ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig_q <= '0;
    else
      sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Replays the LCG stimulus stream into a flat DUT input vector,
// sequences DUT reset and compacts responses into a MISR signature.
module fuzz_stim_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int          IN_W     = 137,
  parameter int          OUT_W    = 159,
  parameter int          CNT_W    = 32,
  parameter int          RST_HOLD = 2,
  parameter logic [31:0] SEED_DEF = 32'd353789296
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_vld,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic [CNT_W-1:0] step_cnt,
  output logic [31:0]      signature
);

  localparam int NWORDS = (IN_W + 31) / 32;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  seq_state_e        state_q;
  logic [31:0]       lcg_q;
  logic [IN_W-1:0]   stage_q;
  logic [IN_W-1:0]   stage_d;
  logic [IN_W-1:0]   din_q;
  logic [IDX_W-1:0]  idx_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  step_q;
  logic              busy_q;
  logic              done_q;
  logic              drst_q;

  logic [31:0]         lcg_nx;
  logic [FOLD_MAX-1:0] fold_in;
  logic                accept;

  assign lcg_nx = lcg_next(lcg_q);
  assign accept = (state_q == IDLE) && start;

  // Bits past IN_W in the last word simply have no home, which truncates it.
  always_comb begin
    stage_d = stage_q;
    for (int b = 0; b < IN_W; b++)
      if (idx_q == IDX_W'(b / 32))
        stage_d[b] = lcg_nx[b % 32];
  end

  always_comb begin
    fold_in = '0;
    fold_in[OUT_W-1:0] = dut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lcg_q   <= '0;
      stage_q <= '0;
      din_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      cyc_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drst_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            lcg_q   <= seed_vld ? seed : SEED_DEF;
            step_q  <= '0;
            idx_q   <= '0;
            cyc_q   <= cycles;
            busy_q  <= 1'b1;
            drst_q  <= 1'b0;
            state_q <= GEN0;
          end
        end
        GEN0, GEN: begin
          lcg_q   <= lcg_nx;
          stage_q <= stage_d;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (state_q == GEN0) begin
              din_q   <= stage_d;
              hold_q  <= '0;
              state_q <= RHOLD;
            end else begin
              state_q <= APPLY;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        RHOLD: begin
          if (hold_q == HOLD_LAST) begin
            drst_q <= 1'b1;
            if (cyc_q != '0) begin
              state_q <= GEN;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        APPLY: begin
          din_q  <= stage_q;
          step_q <= step_q + CNT_W'(1);
          if (step_q + CNT_W'(1) == cyc_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= GEN;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fuzz_misr32 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q == APPLY),
    .din   (fold32(fold_in)),
    .sig   (signature)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign dut_rst_n = drst_q;
  assign dut_in    = din_q;
  assign step_cnt  = step_q;

endmodule
